// File: rtl/vc_dest_arbiter_pkg.sv
// Shared definitions for the VC-to-destination arbiter: FSM encoding and
// channel/destination index and select constants.
package vc_dest_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_t;

    // Virtual-channel indices, also the value carried on grant_vc
    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    // One-hot selects for the pop vector (VC side) and push vector (D side)
    localparam logic [1:0] VC0_SEL = 2'b01;
    localparam logic [1:0] VC1_SEL = 2'b10;
    localparam logic [1:0] D0_SEL  = 2'b01;
    localparam logic [1:0] D1_SEL  = 2'b10;

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// Bus between the VC FIFO heads, the arbiter and the destination FIFO inputs.
// master: the arbiter (pops VCs, pushes Ds). slave: the FIFO side.
interface vc_dest_arbiter_if #(
    parameter int DATA_W = 6
);
    logic [DATA_W-1:0] vc0_data;
    logic [DATA_W-1:0] vc1_data;
    logic [1:0]        vc_empty;
    logic [1:0]        d_almost_full;
    logic [1:0]        vc_pop;
    logic [1:0]        d_push;
    logic [DATA_W-1:0] d_data;

    modport master (
        input  vc0_data, vc1_data, vc_empty, d_almost_full,
        output vc_pop, d_push, d_data
    );

    modport slave (
        output vc0_data, vc1_data, vc_empty, d_almost_full,
        input  vc_pop, d_push, d_data
    );
endinterface

// File: rtl/vc_dest_arbiter_burst_counter.sv
// Saturating burst counter: clear to 0, load 1 on an owner switch, or count
// up towards the current owner's weight and stick there.
module vc_burst_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt
);

    // Counter register; clear has priority over load, load over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc && (cnt < limit)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vc_dest_arbiter.sv
// Weighted round-robin arbiter moving one word per cycle from VC0/VC1 into
// D0/D1. Bit DATA_W-1 of a word picks its destination. Pop is combinational,
// the push/data pair is registered one cycle later.
module vc_dest_arbiter
    import vc_dest_arbiter_pkg::*;
#(
    parameter int DATA_W     = 6,
    parameter int VC0_WEIGHT = 4,
    parameter int VC1_WEIGHT = 1,
    parameter int CNT_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active_in,
    vc_dest_arbiter_if.master  bus,
    output logic               grant_vc,
    output logic               busy
);

    localparam logic [CNT_W-1:0] W0 = CNT_W'(VC0_WEIGHT);
    localparam logic [CNT_W-1:0] W1 = CNT_W'(VC1_WEIGHT);

    arb_state_t        state;
    logic [1:0]        elig;
    logic              other;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  w_own;
    logic              grant_any;
    logic              grant_sel;
    logic              cnt_inc;
    logic              cnt_load;
    logic              cnt_clear;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        dest_sel;
    logic [1:0]        push_p1;
    logic [DATA_W-1:0] data_p1;

    // A VC is eligible when the link is up, it has a word, and that word's
    // destination is not almost full (blocked heads are never bypassed)
    assign elig[VC0] = active_in & ~bus.vc_empty[VC0] & ~bus.d_almost_full[bus.vc0_data[DATA_W-1]];
    assign elig[VC1] = active_in & ~bus.vc_empty[VC1] & ~bus.d_almost_full[bus.vc1_data[DATA_W-1]];

    // Selection: keep the owner until its weight is used up while the other
    // VC waits, otherwise hand over; no eligible VC drops back to idle
    always_comb begin
        other     = ~grant_vc;
        w_own     = (grant_vc == VC1) ? W1 : W0;
        grant_any = 1'b0;
        grant_sel = grant_vc;
        cnt_inc   = 1'b0;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        if (elig[grant_vc] && ((cnt < w_own) || !elig[other])) begin
            grant_any = 1'b1;
            grant_sel = grant_vc;
            cnt_inc   = 1'b1;
        end else if (elig[other]) begin
            grant_any = 1'b1;
            grant_sel = other;
            cnt_load  = 1'b1;
        end else begin
            cnt_clear = 1'b1;
        end
    end

    assign sel_data   = (grant_sel == VC1) ? bus.vc1_data : bus.vc0_data;
    assign dest_sel   = sel_data[DATA_W-1] ? D1_SEL : D0_SEL;
    assign bus.vc_pop = (grant_any && reset) ? ((grant_sel == VC1) ? VC1_SEL : VC0_SEL) : 2'b00;

    vc_burst_counter #(
        .CNT_W (CNT_W)
    ) u_burst_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .limit (w_own),
        .cnt   (cnt)
    );

    // FSM plus output stage: a granted word is pushed on the following cycle,
    // d_data holds its last value when nothing is granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_vc <= VC0;
            push_p1  <= 2'b00;
            data_p1  <= '0;
        end else if (grant_any) begin
            state    <= (grant_sel == VC1) ? SERVE1 : SERVE0;
            grant_vc <= grant_sel;
            push_p1  <= dest_sel;
            data_p1  <= sel_data;
        end else begin
            state    <= IDLE;
            push_p1  <= 2'b00;
        end
    end

    assign bus.d_push = push_p1;
    assign bus.d_data = data_p1;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Scoreboard bench for vc_dest_arbiter: directed tests push hand-computed
// pops and pushes into queues, a negedge monitor checks every DUT pop/push.
module tb_vc_dest_arbiter;

    localparam int DW = 6;

    typedef struct {
        logic [1:0]    push;
        logic [DW-1:0] data;
        logic          vc;
    } push_t;

    logic clk;
    logic reset;
    logic active_in;
    logic grant_vc;
    logic busy;

    vc_dest_arbiter_if #(.DATA_W(DW)) bus ();

    vc_dest_arbiter #(
        .DATA_W     (DW),
        .VC0_WEIGHT (4),
        .VC1_WEIGHT (1),
        .CNT_W      (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .active_in (active_in),
        .bus       (bus.master),
        .grant_vc  (grant_vc),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] vc0_q[$];
    logic [DW-1:0] vc1_q[$];
    logic [1:0]    exp_pop[$];
    push_t         exp_push[$];
    logic [1:0]    last_pop = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // FIFO heads shown to the DUT follow the bench queues
    task automatic refresh();
        bus.vc_empty[0] = (vc0_q.size() == 0);
        bus.vc_empty[1] = (vc1_q.size() == 0);
        bus.vc0_data    = (vc0_q.size() != 0) ? vc0_q[0] : '0;
        bus.vc1_data    = (vc1_q.size() != 0) ? vc1_q[0] : '0;
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (last_pop[0] && vc0_q.size() != 0) void'(vc0_q.pop_front());
        if (last_pop[1] && vc1_q.size() != 0) void'(vc1_q.pop_front());
        refresh();
    endtask

    task automatic expect_word(input logic vc, input logic [DW-1:0] w);
        push_t e;
        exp_pop.push_back(vc ? 2'b10 : 2'b01);
        e.push = w[DW-1] ? 2'b10 : 2'b01;
        e.data = w;
        e.vc   = vc;
        exp_push.push_back(e);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_pops_drained"}, 32'(exp_pop.size()), 32'd0);
        chk({tag, "_pushes_drained"}, 32'(exp_push.size()), 32'd0);
    endtask

    // Monitor: every pop and push the DUT presents is matched in order
    always @(negedge clk) begin
        push_t e;
        last_pop = bus.vc_pop;
        if (reset) begin
            chk("pop_onehot0", 32'($onehot0(bus.vc_pop)), 32'd1);
            if (bus.vc_pop != 2'b00) begin
                if (exp_pop.size() == 0) chk("unexpected_pop", 32'(bus.vc_pop), 32'd0);
                else chk("vc_pop", 32'(bus.vc_pop), 32'(exp_pop.pop_front()));
            end
            if (bus.d_push != 2'b00) begin
                if (exp_push.size() == 0) begin
                    chk("unexpected_push", 32'(bus.d_push), 32'd0);
                end else begin
                    e = exp_push.pop_front();
                    chk("d_push", 32'(bus.d_push), 32'(e.push));
                    chk("d_data", 32'(bus.d_data), 32'(e.data));
                    chk("grant_vc", 32'(grant_vc), 32'(e.vc));
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        active_in       = 1'b0;
        bus.vc_empty    = 2'b11;
        bus.d_almost_full = 2'b00;
        bus.vc0_data    = '0;
        bus.vc1_data    = '0;

        // 1: reset with random inputs
        #2;
        reset             = 1'b0;
        active_in         = 1'b1;
        bus.vc_empty      = 2'($urandom);
        bus.d_almost_full = 2'($urandom);
        bus.vc0_data      = DW'($urandom);
        bus.vc1_data      = DW'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_vc_pop", 32'(bus.vc_pop), 32'd0);
        chk("rst_d_push", 32'(bus.d_push), 32'd0);
        chk("rst_d_data", 32'(bus.d_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_vc", 32'(grant_vc), 32'd0);
        @(posedge clk);
        #1;
        active_in         = 1'b0;
        bus.d_almost_full = 2'b00;
        refresh();
        reset             = 1'b1;
        step();
        @(negedge clk);
        chk("idle_after_release", 32'(busy), 32'd0);

        // 2: VC0 alone, three words to D0
        step();
        active_in = 1'b1;
        vc0_q.push_back(6'h01); expect_word(1'b0, 6'h01);
        vc0_q.push_back(6'h02); expect_word(1'b0, 6'h02);
        vc0_q.push_back(6'h03); expect_word(1'b0, 6'h03);
        refresh();
        repeat (6) step();
        drained("t2");

        // 3: both VCs loaded, all to D1, 4:1 weighting
        for (int i = 0; i < 8; i++) vc0_q.push_back(DW'(6'h20 + i));
        vc1_q.push_back(6'h30);
        vc1_q.push_back(6'h31);
        expect_word(1'b0, 6'h20); expect_word(1'b0, 6'h21);
        expect_word(1'b0, 6'h22); expect_word(1'b0, 6'h23);
        expect_word(1'b1, 6'h30);
        expect_word(1'b0, 6'h24); expect_word(1'b0, 6'h25);
        expect_word(1'b0, 6'h26); expect_word(1'b0, 6'h27);
        expect_word(1'b1, 6'h31);
        refresh();
        repeat (13) step();
        drained("t3");

        // 4: VC0 head blocked by D0 almost full, VC1 to D1 goes through
        bus.d_almost_full = 2'b01;
        vc0_q.push_back(6'h05);
        vc1_q.push_back(6'h3A);
        expect_word(1'b1, 6'h3A);
        expect_word(1'b0, 6'h05);
        refresh();
        repeat (3) step();
        @(negedge clk);
        chk("blocked_no_pop", 32'(bus.vc_pop), 32'd0);
        chk("blocked_idle", 32'(busy), 32'd0);
        step();
        bus.d_almost_full = 2'b00;
        repeat (4) step();
        drained("t4");

        // 5: active_in drops the cycle after a pop
        vc0_q.push_back(6'h07);
        vc0_q.push_back(6'h08);
        expect_word(1'b0, 6'h07);
        refresh();
        step();
        active_in = 1'b0;
        @(negedge clk);
        chk("inactive_no_pop", 32'(bus.vc_pop), 32'd0);
        chk("inactive_busy_hold", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        chk("inactive_busy_clear", 32'(busy), 32'd0);
        chk("inactive_no_push", 32'(bus.d_push), 32'd0);
        chk("d_data_hold", 32'(bus.d_data), 32'h07);
        vc0_q.delete();
        refresh();
        step();
        drained("t5");

        // 6: reset the cycle after a pop drops the in-flight word
        active_in = 1'b1;
        vc0_q.push_back(6'h11);
        exp_pop.push_back(2'b01);
        refresh();
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_d_push", 32'(bus.d_push), 32'd0);
        chk("mid_rst_d_data", 32'(bus.d_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant_vc", 32'(grant_vc), 32'd0);
        chk("mid_rst_vc_pop", 32'(bus.vc_pop), 32'd0);
        step();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("post_rst_d_data", 32'(bus.d_data), 32'd0);
        drained("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
